// File: rtl/axi_bram_pkg.sv
// Shared types for the AXI4 burst BRAM slave: burst codes, response codes,
// FSM state encodings and the WRAP length check.
package axi_bram_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) ||
           (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_bram_addr_gen.sv
// Next-beat byte address for FIXED / INCR / WRAP bursts.
// Ports: addr (current), burst, len (beats-1) in; next_addr out.
module axi_bram_addr_gen
  import axi_bram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            burst,
  input  logic [7:0]            len,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  localparam int AW    = ADDR_WIDTH;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);

  logic [AW-1:0] incr;
  logic [AW-1:0] mask;

  always_comb begin
    incr = addr + AW'(BYTES);
    // Legal wrap lengths are 2^n-1, so the window mask is len:ones.
    mask = (AW'(len) << LSB) | AW'(BYTES - 1);
    next_addr = incr;
    unique case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr;
      BURST_WRAP:  next_addr = (addr & ~mask) | (incr & mask);
      default:     next_addr = incr;
    endcase
  end

endmodule

// File: rtl/axi_bram_burst_slave.sv
// AXI4 burst slave backed by a byte-enabled block RAM; independent read
// and write FSMs. Ports: AW/W/B and AR/R channels, S_AXI_ACLK, S_AXI_ARESET.
// Define AXI_BRAM_WRAP_EN to accept WRAP bursts of LEN 1/3/7/15.
module axi_bram_burst_slave
  import axi_bram_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int C_S_AXI_ID_WIDTH   = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int IW    = C_S_AXI_ID_WIDTH;
  localparam int BYTES = DW / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int DEPTH = 2 ** (AW - LSB);

  logic [DW-1:0] mem [DEPTH];

  // ---------------- write side ----------------
  w_state_t      w_state, w_next;
  logic [AW-1:0] w_addr, w_addr_nx;
  logic [7:0]    w_len, w_cnt;
  logic [1:0]    w_burst;
  logic [IW-1:0] b_id;
  logic          w_err, w_lerr;
  logic [1:0]    b_resp;
  logic          aw_rdy, w_rdy, b_vld;
  logic          aw_hs, w_hs, w_end, w_mis;
  logic          aw_bad, mem_we;

`ifdef AXI_BRAM_WRAP_EN
  assign aw_bad = (S_AXI_AWBURST == BURST_RSVD) ||
                  ((S_AXI_AWBURST == BURST_WRAP) &&
                   !wrap_len_ok(S_AXI_AWLEN));
`else
  assign aw_bad = (S_AXI_AWBURST == BURST_RSVD) ||
                  (S_AXI_AWBURST == BURST_WRAP);
`endif

  assign aw_hs  = aw_rdy && S_AXI_AWVALID;
  assign w_hs   = w_rdy && S_AXI_WVALID;
  assign w_end  = (w_cnt == w_len);
  assign w_mis  = S_AXI_WLAST != w_end;
  assign mem_we = w_hs && !w_err;

  axi_bram_addr_gen #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) u_w_addr (
    .addr     (w_addr),
    .burst    (w_burst),
    .len      (w_len),
    .next_addr(w_addr_nx)
  );

  always_comb begin
    w_next = w_state;
    aw_rdy = 1'b0;
    w_rdy  = 1'b0;
    b_vld  = 1'b0;
    unique case (1'b1)
      (w_state == W_IDLE): begin
        aw_rdy = 1'b1;
        if (S_AXI_AWVALID) w_next = W_DATA;
      end
      (w_state == W_DATA): begin
        w_rdy = 1'b1;
        if (S_AXI_WVALID && w_end) w_next = W_RESP;
      end
      (w_state == W_RESP): begin
        b_vld = 1'b1;
        if (S_AXI_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_burst <= '0;
      b_id    <= '0;
      w_err   <= 1'b0;
      w_lerr  <= 1'b0;
      b_resp  <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        w_addr  <= S_AXI_AWADDR;
        w_len   <= S_AXI_AWLEN;
        w_burst <= S_AXI_AWBURST;
        b_id    <= S_AXI_AWID;
        w_cnt   <= '0;
        w_err   <= aw_bad;
        w_lerr  <= 1'b0;
      end
      if (w_hs) begin
        w_addr <= w_addr_nx;
        w_cnt  <= w_cnt + 8'd1;
        if (w_mis) w_lerr <= 1'b1;
        // Burst ends on the beat count regardless of WLAST.
        if (w_end)
          b_resp <= (w_err || w_lerr || w_mis) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (S_AXI_WSTRB[b])
          mem[w_addr[AW-1:LSB]][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
      end
    end
  end

  assign S_AXI_AWREADY = aw_rdy && !S_AXI_ARESET;
  assign S_AXI_WREADY  = w_rdy;
  assign S_AXI_BVALID  = b_vld;
  assign S_AXI_BRESP   = b_resp;
  assign S_AXI_BID     = b_id;

  // ---------------- read side ----------------
  r_state_t      r_state, r_next;
  logic [AW-1:0] r_addr, r_addr_nx;
  logic [7:0]    r_len, r_cnt;
  logic [1:0]    r_burst;
  logic [IW-1:0] r_id;
  logic          r_err, r_valid, r_last;
  logic [DW-1:0] r_data;
  logic [1:0]    r_resp;
  logic          ar_rdy, ar_hs, ar_bad, fetch, r_done;

`ifdef AXI_BRAM_WRAP_EN
  assign ar_bad = (S_AXI_ARBURST == BURST_RSVD) ||
                  ((S_AXI_ARBURST == BURST_WRAP) &&
                   !wrap_len_ok(S_AXI_ARLEN));
`else
  assign ar_bad = (S_AXI_ARBURST == BURST_RSVD) ||
                  (S_AXI_ARBURST == BURST_WRAP);
`endif

  assign ar_hs  = ar_rdy && S_AXI_ARVALID;
  assign r_done = r_valid && S_AXI_RREADY && r_last;
  // Refill the output register when empty or when its beat is taken,
  // unless that beat was the last one.
  assign fetch  = (r_state == R_DATA) &&
                  (!r_valid || S_AXI_RREADY) && !r_done;

  axi_bram_addr_gen #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) u_r_addr (
    .addr     (r_addr),
    .burst    (r_burst),
    .len      (r_len),
    .next_addr(r_addr_nx)
  );

  always_comb begin
    r_next = r_state;
    ar_rdy = 1'b0;
    unique case (1'b1)
      (r_state == R_IDLE): begin
        ar_rdy = 1'b1;
        if (S_AXI_ARVALID) r_next = R_DATA;
      end
      (r_state == R_DATA): begin
        if (r_done) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_burst <= '0;
      r_id    <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_resp  <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        r_addr  <= S_AXI_ARADDR;
        r_len   <= S_AXI_ARLEN;
        r_burst <= S_AXI_ARBURST;
        r_id    <= S_AXI_ARID;
        r_err   <= ar_bad;
        r_cnt   <= '0;
      end
      if (r_done) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
      if (fetch) begin
        r_data  <= r_err ? '0 : mem[r_addr[AW-1:LSB]];
        r_resp  <= r_err ? RESP_SLVERR : RESP_OKAY;
        r_valid <= 1'b1;
        r_last  <= (r_cnt == r_len);
        r_addr  <= r_addr_nx;
        r_cnt   <= r_cnt + 8'd1;
      end
    end
  end

  assign S_AXI_ARREADY = ar_rdy && !S_AXI_ARESET;
  assign S_AXI_RVALID  = r_valid;
  assign S_AXI_RLAST   = r_last;
  assign S_AXI_RDATA   = r_data;
  assign S_AXI_RRESP   = r_resp;
  assign S_AXI_RID     = r_id;

endmodule

// File: tb/tb_axi_bram_burst_slave.sv
// Directed bench for axi_bram_burst_slave; queued expectations are
// checked by a monitor whenever a B or R handshake is presented.
module tb_axi_bram_burst_slave;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;
  localparam logic [1:0] RSVD  = 2'b11;
  localparam logic [1:0] OK    = 2'b00;
  localparam logic [1:0] SERR  = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awid, bid, arid, rid;
  logic [11:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready, arvalid, arready;
  logic        rlast, rvalid, rready;

  always #5 clk = ~clk;

  axi_bram_burst_slave dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .S_AXI_AWID   (awid),
    .S_AXI_AWADDR (awaddr),
    .S_AXI_AWLEN  (awlen),
    .S_AXI_AWBURST(awburst),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA  (wdata),
    .S_AXI_WSTRB  (wstrb),
    .S_AXI_WLAST  (wlast),
    .S_AXI_WVALID (wvalid),
    .S_AXI_WREADY (wready),
    .S_AXI_BID    (bid),
    .S_AXI_BRESP  (bresp),
    .S_AXI_BVALID (bvalid),
    .S_AXI_BREADY (bready),
    .S_AXI_ARID   (arid),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARLEN  (arlen),
    .S_AXI_ARBURST(arburst),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RID    (rid),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RLAST  (rlast),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready)
  );

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [1:0]  resp;
    logic        last;
    logic [31:0] data;
  } r_exp_t;

  b_exp_t      bq[$];
  r_exp_t      rq[$];
  b_exp_t      be;
  r_exp_t      re;
  int          total = 0;
  int          passed = 0;
  logic [31:0] wbuf [16];
  logic [31:0] rbuf [16];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (bvalid && bready) begin
      if (bq.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
      else begin
        be = bq.pop_front();
        chk("b_resp", 64'({bid, bresp}), 64'(be));
      end
    end
    if (rvalid && rready) begin
      if (rq.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
      else begin
        re = rq.pop_front();
        chk("r_beat", 64'({rid, rresp, rlast, rdata}), 64'(re));
      end
    end
  end

  task automatic write_burst(input logic [11:0] a, input logic [7:0] len,
                             input logic [1:0] bt, input logic [3:0] id,
                             input logic [3:0] strb, input int last_at,
                             input logic [1:0] er);
    int n;
    bq.push_back(b_exp_t'({id, er}));
    awaddr = a; awlen = len; awburst = bt; awid = id; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("aw_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wbuf[i]; wstrb = strb; wlast = (i == last_at);
      wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) chk("w_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("b_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic read_burst(input logic [11:0] a, input logic [7:0] len,
                            input logic [1:0] bt, input logic [3:0] id,
                            input int stall_at, input logic [1:0] er);
    int n, beats;
    logic stalled;
    for (int i = 0; i <= int'(len); i++)
      rq.push_back(r_exp_t'({id, er, 1'(i == int'(len)), rbuf[i]}));
    araddr = a; arlen = len; arburst = bt; arid = id; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("ar_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("r_lat1", 64'(rvalid), 64'd0);
    @(posedge clk); #1;
    chk("r_lat2", 64'(rvalid), 64'd1);
    beats = 0; stalled = 1'b0; n = 0;
    while (beats <= int'(len) && n < 200) begin
      if (rvalid) begin
        if (beats == stall_at && !stalled) begin
          rready = 1'b0; stalled = 1'b1;
          repeat (5) begin
            @(posedge clk); #1;
            chk("r_hold", 64'({rvalid, rlast, rid, rdata}),
                64'({1'b1, 1'(stall_at == int'(len)), id, rbuf[stall_at]}));
          end
          rready = 1'b1;
        end
        beats++;
      end
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("r_timeout", 64'd1, 64'd0);
    chk("r_idle", 64'(rvalid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs",
        64'({awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp}),
        64'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready", 64'({awready, arready}), 64'b11);
    @(posedge clk); #1;

    // INCR 8-beat write and read back
    for (int i = 0; i < 8; i++) wbuf[i] = 32'(i + 1);
    write_burst(12'h000, 8'd7, INCR, 4'd3, 4'hF, 7, OK);
    for (int i = 0; i < 8; i++) rbuf[i] = 32'(i + 1);
    read_burst(12'h000, 8'd7, INCR, 4'd5, -1, OK);

    // byte strobes
    wbuf[0] = 32'h11223344;
    write_burst(12'h010, 8'd0, INCR, 4'd1, 4'hF, 0, OK);
    wbuf[0] = 32'hAABBCCDD;
    write_burst(12'h010, 8'd0, INCR, 4'd2, 4'b0101, 0, OK);
    rbuf[0] = 32'h11BB33DD;
    read_burst(12'h010, 8'd0, INCR, 4'd4, -1, OK);

    // WRAP LEN 3 at 0x08
    wbuf[0] = 32'hA0; wbuf[1] = 32'hA1; wbuf[2] = 32'hA2; wbuf[3] = 32'hA3;
`ifdef AXI_BRAM_WRAP_EN
    write_burst(12'h008, 8'd3, WRAP, 4'd6, 4'hF, 3, OK);
    rbuf[0] = 32'hA2; rbuf[1] = 32'hA3; rbuf[2] = 32'hA0; rbuf[3] = 32'hA1;
`else
    write_burst(12'h008, 8'd3, WRAP, 4'd6, 4'hF, 3, SERR);
    rbuf[0] = 32'd1; rbuf[1] = 32'd2; rbuf[2] = 32'd3; rbuf[3] = 32'd4;
`endif
    read_burst(12'h000, 8'd3, INCR, 4'd7, -1, OK);

    // backpressure on beat index 2
    rbuf[0] = 32'h11BB33DD; rbuf[1] = 32'd6; rbuf[2] = 32'd7;
    rbuf[3] = 32'd8;
    read_burst(12'h010, 8'd3, INCR, 4'd9, 2, OK);

    // early WLAST: data lands, response is SLVERR
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hC0 + 32'(i);
    write_burst(12'h040, 8'd7, INCR, 4'd10, 4'hF, 3, SERR);
    for (int i = 0; i < 8; i++) rbuf[i] = 32'hC0 + 32'(i);
    read_burst(12'h040, 8'd7, INCR, 4'd11, -1, OK);

    // reserved burst type
    wbuf[0] = 32'h5555_0000; wbuf[1] = 32'h5555_0001;
    write_burst(12'h080, 8'd1, INCR, 4'd12, 4'hF, 1, OK);
    wbuf[0] = 32'h9999_0000; wbuf[1] = 32'h9999_0001;
    write_burst(12'h080, 8'd1, RSVD, 4'd13, 4'hF, 1, SERR);
    rbuf[0] = 32'h5555_0000; rbuf[1] = 32'h5555_0001;
    read_burst(12'h080, 8'd1, INCR, 4'd14, -1, OK);
    rbuf[0] = 32'h0; rbuf[1] = 32'h0;
    read_burst(12'h080, 8'd1, RSVD, 4'd15, -1, SERR);

    // INCR wraps modulo memory size
    wbuf[0] = 32'hE0; wbuf[1] = 32'hE1;
    write_burst(12'hFFC, 8'd1, INCR, 4'd1, 4'hF, 1, OK);
    rbuf[0] = 32'hE0; rbuf[1] = 32'hE1;
    read_burst(12'hFFC, 8'd1, INCR, 4'd2, -1, OK);

    // FIXED holds address
    wbuf[0] = 32'hD0; wbuf[1] = 32'hD1; wbuf[2] = 32'hD2;
    write_burst(12'h200, 8'd2, FIXED, 4'd3, 4'hF, 2, OK);
    rbuf[0] = 32'hD2; rbuf[1] = 32'hD2;
    read_burst(12'h200, 8'd1, FIXED, 4'd4, -1, OK);

    // reset in the middle of a read
    rready = 1'b0;
    araddr = 12'h040; arlen = 8'd7; arburst = INCR; arid = 4'd8;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
    chk("mid_rvalid", 64'(rvalid), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid", 64'({rvalid, rlast, arready, awready}), 64'd0);
    rst = 1'b0;
    #1;
    chk("rel_mid", 64'({arready, awready}), 64'b11);
    rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", 64'(rvalid), 64'd0);

    // memory survives reset
    rbuf[0] = 32'hD2;
    read_burst(12'h200, 8'd0, FIXED, 4'd5, -1, OK);

    n = 0;
    while ((bq.size() + rq.size()) != 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("q_empty", 64'(bq.size() + rq.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi_bram_burst_slave.md
AXI_BRAM_BURST_SLAVE -- requirements
Module: axi_bram_burst_slave
Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data bus width in bits (32, 64 or 128).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 12, byte address width; memory size 2^C_S_AXI_ADDR_WIDTH bytes.
REQ-003 SHALL have parameter C_S_AXI_ID_WIDTH, default 4, transaction ID width.
REQ-004 SHALL have port S_AXI_ACLK in 1 -- the single clock; all logic on rising edge.
REQ-005 SHALL have port S_AXI_ARESET in 1 -- asynchronous, active-high reset.
REQ-006 SHALL have port S_AXI_AWID in ID -- write ID.
REQ-007 SHALL have port S_AXI_AWADDR in ADDR -- write start byte address.
REQ-008 SHALL have port S_AXI_AWLEN in 8 -- beats minus one.
REQ-009 SHALL have port S_AXI_AWBURST in 2 -- FIXED/INCR/WRAP.
REQ-010 SHALL have port S_AXI_AWVALID in 1 -- AW valid.
REQ-011 SHALL have port S_AXI_AWREADY out 1 -- AW ready.
REQ-012 SHALL have port S_AXI_WDATA in DATA -- write data.
REQ-013 SHALL have port S_AXI_WSTRB in DATA/8 -- byte enables.
REQ-014 SHALL have port S_AXI_WLAST in 1 -- last write beat.
REQ-015 SHALL have port S_AXI_WVALID in 1 -- W valid.
REQ-016 SHALL have port S_AXI_WREADY out 1 -- W ready.
REQ-017 SHALL have port S_AXI_BID out ID -- echoed AWID.
REQ-018 SHALL have port S_AXI_BRESP out 2 -- OKAY 00 / SLVERR 10.
REQ-019 SHALL have port S_AXI_BVALID out 1 -- B valid.
REQ-020 SHALL have port S_AXI_BREADY in 1 -- B ready.
REQ-021 SHALL have port S_AXI_ARID in ID -- read ID.
REQ-022 SHALL have port S_AXI_ARADDR in ADDR -- read start byte address.
REQ-023 SHALL have port S_AXI_ARLEN in 8 -- beats minus one.
REQ-024 SHALL have port S_AXI_ARBURST in 2 -- burst type.
REQ-025 SHALL have port S_AXI_ARVALID in 1 -- AR valid.
REQ-026 SHALL have port S_AXI_ARREADY out 1 -- AR ready.
REQ-027 SHALL have port S_AXI_RID out ID -- echoed ARID.
REQ-028 SHALL have port S_AXI_RDATA out DATA -- read data.
REQ-029 SHALL have port S_AXI_RRESP out 2 -- read response.
REQ-030 SHALL have port S_AXI_RLAST out 1 -- last read beat.
REQ-031 SHALL have port S_AXI_RVALID out 1 -- R valid.
REQ-032 SHALL have port S_AXI_RREADY in 1 -- R ready.
Function
REQ-033 SHALL use write FSM W_IDLE->W_DATA (AW handshake; AWREADY=1 only in W_IDLE)->W_RESP (beat count reaches AWLEN)->W_IDLE (B handshake); WREADY=1 only in W_DATA; BVALID held until BREADY.
REQ-034 SHALL write each accepted W beat to the addressed word, only bytes with WSTRB=1; size always full bus width, address low log2(DATA/8) bits ignored.
REQ-035 SHALL use read FSM R_IDLE->R_DATA (AR handshake)->R_IDLE (handshake of beat ARLEN); first RVALID 2 cycles after AR handshake; RDATA/RLAST/RID stable while RVALID=1 and RREADY=0; RLAST=1 only on beat ARLEN.
REQ-036 SHALL advance addresses: FIXED holds, INCR adds DATA/8 and wraps modulo memory size, WRAP per AXI4 within a (ARLEN+1)*DATA/8 aligned window.
REQ-037 SHALL give BRESP=SLVERR if WLAST mismatches beat AWLEN (burst still terminates on beat count), or burst type 11 (no bytes written); reads of type 11 return RRESP=SLVERR, RDATA=0, full beat count.
REQ-038 SHALL run read and write FSMs concurrently; same-word read and write in one cycle returns old data.
Reset
REQ-039 SHALL, while S_AXI_ARESET=1, force both FSMs idle and AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST=0, BRESP/RRESP=00; memory contents not reset; AWREADY/ARREADY=1 first cycle after release; reset mid-burst abandons the burst.
Configuration
REQ-040 SHALL, with AXI_BRAM_WRAP_EN defined, support WRAP for LEN 1, 3, 7, 15 (other LEN -> SLVERR as REQ-037); without it, WRAP bursts SHALL be treated as type 11.
Structure
REQ-041 SHALL take burst/response/state enums and RESP constants from package axi_bram_pkg; next-address logic in sub-module axi_bram_addr_gen, instantiated once per FSM.
Verification
REQ-042 INCR write addr 0x0, LEN 7, data 1..8, then read -> BRESP=00, RDATA 1..8, RLAST on beat 8 only.
REQ-043 Write 0xAABBCCDD to 0x10 with WSTRB=0101 over 0x11223344 -> read 0x11BB33DD.
REQ-044 WRAP LEN 3 at 0x08 (32-bit, macro on) -> words written at 0x08,0x0C,0x00,0x04; macro off -> BRESP=10, memory unchanged.
REQ-045 Read LEN 3 with RREADY low 5 cycles on beat 2 -> RDATA held stable, 4 beats, RID=ARID.
REQ-046 WLAST on beat 3 of LEN 7 write -> BRESP=10 after 8 beats; reset asserted mid-read -> RVALID=0 next edge, ARREADY=1 after release.
